spu_dual_issue: RTL and testbench

//  In-order dual-issue stage directly upstream of spu_pipes_top.
//  - Accepts one decoded instruction pair per handshake.
//  - Steers each instruction to the even or odd pipe.
//  - Stalls on pipe conflicts and on RAW hazards using a per-register latency scoreboard.
//  - Drives opcode, register addresses and immediate for each pipe from registered outputs.

---
 rtl/spu_dual_issue.sv | 235 +++++++++++++++++++++++
 tb/tb_spu_dual_issue.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_dual_issue.sv
// spu_dual_issue: in-order dual-issue stage ahead of the even/odd SPU pipes.
// Optional perf counters are built when SPU_ISSUE_PERF_EN is defined.
module spu_dual_issue #(
  parameter int OPCODE_LEN = 11,
  parameter logic [OPCODE_LEN-1:0] NOP_EVEN = 11'h201,
  parameter logic [OPCODE_LEN-1:0] NOP_ODD = 11'h001
) (
  input  logic clk,
  input  logic rst,
  input  logic pair_valid,
  output logic pair_ready,
  input  logic s0_valid,
  input  logic s0_pipe,
  input  logic [OPCODE_LEN-1:0] s0_opcode,
  input  logic [6:0] s0_ra,
  input  logic [6:0] s0_rb,
  input  logic [6:0] s0_rc,
  input  logic [2:0] s0_src_use,
  input  logic [6:0] s0_rt,
  input  logic s0_rt_wr,
  input  logic [2:0] s0_lat,
  input  logic [17:0] s0_imm,
  input  logic s1_valid,
  input  logic s1_pipe,
  input  logic [OPCODE_LEN-1:0] s1_opcode,
  input  logic [6:0] s1_ra,
  input  logic [6:0] s1_rb,
  input  logic [6:0] s1_rc,
  input  logic [2:0] s1_src_use,
  input  logic [6:0] s1_rt,
  input  logic s1_rt_wr,
  input  logic [2:0] s1_lat,
  input  logic [17:0] s1_imm,
  output logic [OPCODE_LEN-1:0] opcode_ep,
  output logic [OPCODE_LEN-1:0] opcode_op,
  output logic [6:0] ra_addr_ep,
  output logic [6:0] rb_addr_ep,
  output logic [6:0] rc_addr_ep,
  output logic [6:0] rt_addr_ep,
  output logic [6:0] ra_addr_op,
  output logic [6:0] rb_addr_op,
  output logic [6:0] rc_addr_op,
  output logic [6:0] rt_addr_op,
  output logic [17:0] imm_ep,
  output logic [17:0] imm_op,
  output logic issue_ep,
  output logic issue_op
`ifdef SPU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_dual,
  output logic [31:0] perf_single,
  output logic [31:0] perf_stall
`endif
);

  typedef struct packed {
    logic pipe;
    logic [OPCODE_LEN-1:0] opcode;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [2:0] src_use;
    logic [6:0] rt;
    logic rt_wr;
    logic [2:0] lat;
    logic [17:0] imm;
  } slot_t;

  typedef struct packed {
    logic [OPCODE_LEN-1:0] opcode;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [6:0] rt;
    logic [17:0] imm;
    logic issue;
  } out_t;

  function automatic logic src_rdy(logic u, logic [2:0] c);
    return !u || c == 3'd0;
  endfunction

  function automatic logic [2:0] lm1(logic [2:0] l);
    return (l == 3'd0) ? 3'd0 : l - 3'd1;
  endfunction

  function automatic logic reads(slot_t s, logic [6:0] r);
    return (s.src_use[0] && s.ra == r) ||
           (s.src_use[1] && s.rb == r) ||
           (s.src_use[2] && s.rc == r);
  endfunction

  function automatic out_t to_out(slot_t s);
    out_t o;
    o.opcode = s.opcode;
    o.ra = s.ra;
    o.rb = s.rb;
    o.rc = s.rc;
    o.rt = s.rt;
    o.imm = s.imm;
    o.issue = 1'b1;
    return o;
  endfunction

  function automatic out_t nop(logic [OPCODE_LEN-1:0] op);
    out_t o;
    o = '0;
    o.opcode = op;
    return o;
  endfunction

  slot_t s0_in, s1_in, h0, h1;
  logic [1:0] hv;
  logic [2:0] cnt [128];
  logic [2:0] cnt_n [128];
  logic h0_rdy, h1_rdy, h0_go, h1_go, accept;
  out_t ep_n, op_n, ep_q, op_q;

  assign s0_in = {s0_pipe, s0_opcode, s0_ra, s0_rb, s0_rc,
                  s0_src_use, s0_rt, s0_rt_wr, s0_lat, s0_imm};
  assign s1_in = {s1_pipe, s1_opcode, s1_ra, s1_rb, s1_rc,
                  s1_src_use, s1_rt, s1_rt_wr, s1_lat, s1_imm};

  assign pair_ready = ~rst & ~hv[0] & ~hv[1];
  assign accept = pair_valid & pair_ready;

  assign h0_rdy = src_rdy(h0.src_use[0], cnt[h0.ra]) &
                  src_rdy(h0.src_use[1], cnt[h0.rb]) &
                  src_rdy(h0.src_use[2], cnt[h0.rc]);
  assign h1_rdy = src_rdy(h1.src_use[0], cnt[h1.ra]) &
                  src_rdy(h1.src_use[1], cnt[h1.rb]) &
                  src_rdy(h1.src_use[2], cnt[h1.rc]);

  assign h0_go = hv[0] & h0_rdy;
  assign h1_go = hv[1] & (h0_go | ~hv[0]) & h1_rdy &
                 (~hv[0] |
                  ((h1.pipe != h0.pipe) &
                   ~(h0.rt_wr & reads(h1, h0.rt)) &
                   ~(h0.rt_wr & h1.rt_wr & (h0.rt == h1.rt))));

  // hold slots: capture a pair when empty, retire each slot as it issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv <= '0;
      h0 <= '0;
      h1 <= '0;
    end else if (accept) begin
      h0 <= s0_in;
      h1 <= s1_in;
      hv <= {s1_valid, s0_valid};
    end else begin
      if (h0_go) hv[0] <= 1'b0;
      if (h1_go) hv[1] <= 1'b0;
    end
  end

  // scoreboard next state: decay, then extend for newly issued writers
  always_comb begin
    for (int i = 0; i < 128; i++) begin
      cnt_n[i] = (cnt[i] != 3'd0) ? cnt[i] - 3'd1 : 3'd0;
      if (h0_go && h0.rt_wr && h0.rt == 7'(i) && lm1(h0.lat) > cnt_n[i])
        cnt_n[i] = lm1(h0.lat);
      if (h1_go && h1.rt_wr && h1.rt == 7'(i) && lm1(h1.lat) > cnt_n[i])
        cnt_n[i] = lm1(h1.lat);
    end
  end

  // scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 128; i++) cnt[i] <= cnt_n[i];
    end
  end

  // steer issued slots to their pipes, NOPs elsewhere
  always_comb begin
    ep_n = nop(NOP_EVEN);
    op_n = nop(NOP_ODD);
    if (h0_go) begin
      if (h0.pipe) op_n = to_out(h0);
      else ep_n = to_out(h0);
    end
    if (h1_go) begin
      if (h1.pipe) op_n = to_out(h1);
      else ep_n = to_out(h1);
    end
  end

  // registered pipe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ep_q <= nop(NOP_EVEN);
      op_q <= nop(NOP_ODD);
    end else begin
      ep_q <= ep_n;
      op_q <= op_n;
    end
  end

  assign opcode_ep = ep_q.opcode;
  assign ra_addr_ep = ep_q.ra;
  assign rb_addr_ep = ep_q.rb;
  assign rc_addr_ep = ep_q.rc;
  assign rt_addr_ep = ep_q.rt;
  assign imm_ep = ep_q.imm;
  assign issue_ep = ep_q.issue;
  assign opcode_op = op_q.opcode;
  assign ra_addr_op = op_q.ra;
  assign rb_addr_op = op_q.rb;
  assign rc_addr_op = op_q.rc;
  assign rt_addr_op = op_q.rt;
  assign imm_op = op_q.imm;
  assign issue_op = op_q.issue;

`ifdef SPU_ISSUE_PERF_EN
  // saturating issue-mix counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dual <= '0;
      perf_single <= '0;
      perf_stall <= '0;
    end else begin
      if (h0_go && h1_go && perf_dual != '1)
        perf_dual <= perf_dual + 32'd1;
      if ((h0_go ^ h1_go) && perf_single != '1)
        perf_single <= perf_single + 32'd1;
      if (hv != 2'b00 && !h0_go && !h1_go && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spu_dual_issue.sv
// tb_spu_dual_issue: directed and random checks of the dual-issue stage
// against a ready-time reference model.
module tb_spu_dual_issue;
  localparam logic [10:0] NOP_EVEN = 11'h201;
  localparam logic [10:0] NOP_ODD = 11'h001;

  typedef struct {
    bit v;
    bit pipe;
    bit [10:0] op;
    bit [6:0] ra;
    bit [6:0] rb;
    bit [6:0] rc;
    bit [2:0] srcs;
    bit [6:0] rt;
    bit wr;
    bit [2:0] lat;
    bit [17:0] imm;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pair_valid = 1'b0;
  logic pair_ready;
  ins_t sl [2];
  logic [10:0] opcode_ep, opcode_op;
  logic [6:0] ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [6:0] ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [17:0] imm_ep, imm_op;
  logic issue_ep, issue_op;
`ifdef SPU_ISSUE_PERF_EN
  logic [31:0] perf_dual, perf_single, perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  ins_t q [$];
  int rdy_at [128];
  int ecnt = 0;
  logic [57:0] exp_ep, exp_op;
  logic exp_rdy;
  int m_dual = 0, m_single = 0, m_stall = 0;

  wire [57:0] act_ep = {issue_ep, opcode_ep, ra_addr_ep, rb_addr_ep,
                        rc_addr_ep, rt_addr_ep, imm_ep};
  wire [57:0] act_op = {issue_op, opcode_op, ra_addr_op, rb_addr_op,
                        rc_addr_op, rt_addr_op, imm_op};

  always #5 clk = ~clk;

  spu_dual_issue dut (
    .clk(clk), .rst(rst),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .s0_valid(sl[0].v), .s0_pipe(sl[0].pipe), .s0_opcode(sl[0].op),
    .s0_ra(sl[0].ra), .s0_rb(sl[0].rb), .s0_rc(sl[0].rc),
    .s0_src_use(sl[0].srcs), .s0_rt(sl[0].rt), .s0_rt_wr(sl[0].wr),
    .s0_lat(sl[0].lat), .s0_imm(sl[0].imm),
    .s1_valid(sl[1].v), .s1_pipe(sl[1].pipe), .s1_opcode(sl[1].op),
    .s1_ra(sl[1].ra), .s1_rb(sl[1].rb), .s1_rc(sl[1].rc),
    .s1_src_use(sl[1].srcs), .s1_rt(sl[1].rt), .s1_rt_wr(sl[1].wr),
    .s1_lat(sl[1].lat), .s1_imm(sl[1].imm),
    .opcode_ep(opcode_ep), .opcode_op(opcode_op),
    .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep),
    .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op),
    .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
    .imm_ep(imm_ep), .imm_op(imm_op),
    .issue_ep(issue_ep), .issue_op(issue_op)
`ifdef SPU_ISSUE_PERF_EN
    , .perf_dual(perf_dual), .perf_single(perf_single),
    .perf_stall(perf_stall)
`endif
  );

  function automatic ins_t mk(bit v, bit pipe, bit [10:0] op,
                              bit [6:0] ra, bit [6:0] rb, bit [6:0] rc,
                              bit [2:0] srcs, bit [6:0] rt, bit wr,
                              bit [2:0] lat, bit [17:0] imm);
    ins_t x;
    x.v = v; x.pipe = pipe; x.op = op;
    x.ra = ra; x.rb = rb; x.rc = rc;
    x.srcs = srcs; x.rt = rt; x.wr = wr;
    x.lat = lat; x.imm = imm;
    return x;
  endfunction

  function automatic ins_t rnd();
    ins_t x;
    x.v = 1'($urandom_range(0, 3) != 0);
    x.pipe = 1'($urandom_range(0, 1));
    x.op = 11'($urandom);
    x.ra = 7'($urandom_range(0, 7));
    x.rb = 7'($urandom_range(0, 7));
    x.rc = 7'($urandom_range(0, 7));
    x.srcs = 3'($urandom);
    x.rt = 7'($urandom_range(0, 7));
    x.wr = 1'($urandom_range(0, 1));
    x.lat = 3'($urandom);
    x.imm = 18'($urandom);
    return x;
  endfunction

  // a register is readable from the edge its latest writer's latency expires
  function automatic bit ready(ins_t x, int e);
    return (!x.srcs[0] || e >= rdy_at[x.ra]) &&
           (!x.srcs[1] || e >= rdy_at[x.rb]) &&
           (!x.srcs[2] || e >= rdy_at[x.rc]);
  endfunction

  function automatic bit reads(ins_t x, bit [6:0] r);
    return (x.srcs[0] && x.ra == r) || (x.srcs[1] && x.rb == r) ||
           (x.srcs[2] && x.rc == r);
  endfunction

  function automatic logic [57:0] vec(ins_t x);
    return {1'b1, x.op, x.ra, x.rb, x.rc, x.rt, x.imm};
  endfunction

  // one clock edge of DUT and model; leaves expectations for the caller
  task automatic tick();
    ins_t a, b;
    bit g0, g1, acc;
    int e, l;
    e = ecnt + 1;
    g0 = 0;
    g1 = 0;
    if (!rst && q.size() > 0) begin
      a = q[0];
      g0 = ready(a, e);
      if (q.size() > 1) begin
        b = q[1];
        g1 = g0 && ready(b, e) && b.pipe != a.pipe &&
             !(a.wr && reads(b, a.rt)) &&
             !(a.wr && b.wr && a.rt == b.rt);
      end
    end
    exp_ep = {1'b0, NOP_EVEN, 46'd0};
    exp_op = {1'b0, NOP_ODD, 46'd0};
    if (g0) begin
      if (a.pipe) exp_op = vec(a);
      else exp_ep = vec(a);
    end
    if (g1) begin
      if (b.pipe) exp_op = vec(b);
      else exp_ep = vec(b);
    end
    acc = !rst && pair_valid && q.size() == 0;
    if (!rst) begin
      if (g0 && g1) m_dual++;
      else if (g0 || g1) m_single++;
      else if (q.size() > 0) m_stall++;
    end
    @(posedge clk);
    #1;
    ecnt = e;
    if (rst) begin
      q.delete();
      foreach (rdy_at[i]) rdy_at[i] = 0;
      m_dual = 0; m_single = 0; m_stall = 0;
    end else begin
      if (g0 && a.wr) begin
        l = (a.lat == 0) ? 1 : int'(a.lat);
        if (e + l > rdy_at[a.rt]) rdy_at[a.rt] = e + l;
      end
      if (g1 && b.wr) begin
        l = (b.lat == 0) ? 1 : int'(b.lat);
        if (e + l > rdy_at[b.rt]) rdy_at[b.rt] = e + l;
      end
      if (g1) q.delete(1);
      if (g0) q.delete(0);
      if (acc) begin
        if (sl[0].v) q.push_back(sl[0]);
        if (sl[1].v) q.push_back(sl[1]);
      end
    end
    exp_rdy = !rst && q.size() == 0;
  endtask

  task automatic send(ins_t a, ins_t b);
    sl[0] = a;
    sl[1] = b;
    pair_valid = 1'b1;
    tick();
    pair_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b0 || opcode_ep !== NOP_EVEN ||
        opcode_op !== NOP_ODD || pair_ready !== 1'b0 || act_ep[45:0] !== 46'd0 ||
        act_op[45:0] !== 46'd0)
    begin
      failures++;
      $display("FAIL reset_state ep=%h op=%h rdy=%b", act_ep, act_op, pair_ready);
    end
    tick();
    tick();
    checks++;
    if (act_ep !== exp_ep || act_op !== exp_op || pair_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold ep=%h/%h op=%h/%h rdy=%b/0",
               act_ep, exp_ep, act_op, exp_op, pair_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pair_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release rdy=%b want 1", pair_ready);
    end
  endtask

  task automatic test_indep_pair();
    send(mk(1, 0, 11'h0C0, 1, 2, 0, 3'b011, 3, 1, 2, 18'h00012),
         mk(1, 1, 11'h1D8, 4, 5, 0, 3'b011, 6, 1, 4, 18'h00045));
    tick();
    checks++;
    if (act_ep !== exp_ep || act_op !== exp_op || pair_ready !== exp_rdy) begin
      failures++;
      $display("FAIL indep_model ep=%h/%h op=%h/%h rdy=%b/%b",
               act_ep, exp_ep, act_op, exp_op, pair_ready, exp_rdy);
    end
    checks++;
    if (issue_ep !== 1'b1 || issue_op !== 1'b1 || pair_ready !== 1'b1 ||
        opcode_ep !== 11'h0C0 || opcode_op !== 11'h1D8) begin
      failures++;
      $display("FAIL indep_dual issue=%b%b op=%h/%h rdy=%b want 11 0c0/1d8 1",
               issue_ep, issue_op, opcode_ep, opcode_op, pair_ready);
    end
  endtask

  task automatic test_same_pipe();
    send(mk(1, 0, 11'h0C1, 1, 2, 0, 3'b011, 7, 1, 1, 18'h00011),
         mk(1, 0, 11'h0C2, 4, 5, 0, 3'b011, 8, 1, 1, 18'h00022));
    tick();
    checks++;
    if (issue_ep !== 1'b1 || opcode_ep !== 11'h0C1 || issue_op !== 1'b0) begin
      failures++;
      $display("FAIL same_pipe_c1 issue=%b%b op=%h want 10 0c1",
               issue_ep, issue_op, opcode_ep);
    end
    tick();
    checks++;
    if (issue_ep !== 1'b1 || opcode_ep !== 11'h0C2 || issue_op !== 1'b0 ||
        opcode_op !== NOP_ODD) begin
      failures++;
      $display("FAIL same_pipe_c2 issue=%b%b op=%h/%h want 10 0c2/001",
               issue_ep, issue_op, opcode_ep, opcode_op);
    end
    checks++;
    if (act_ep !== exp_ep || act_op !== exp_op || pair_ready !== exp_rdy) begin
      failures++;
      $display("FAIL same_pipe_model ep=%h/%h op=%h/%h rdy=%b/%b",
               act_ep, exp_ep, act_op, exp_op, pair_ready, exp_rdy);
    end
  endtask

  task automatic test_raw(bit [2:0] lat, bit [6:0] r, int want);
    int got;
    ins_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send(mk(1, 0, 11'h0C3, 1, 0, 0, 3'b001, r, 1, lat, 18'h0), z);
    tick();
    send(mk(1, 1, 11'h0C4, r, 0, 0, 3'b001, 7'd30, 1, 1, 18'h3), z);
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (act_ep !== exp_ep || act_op !== exp_op || pair_ready !== exp_rdy) begin
        failures++;
        $display("FAIL raw_model k=%0d ep=%h/%h op=%h/%h rdy=%b/%b", k,
                 act_ep, exp_ep, act_op, exp_op, pair_ready, exp_rdy);
      end
      if (issue_op === 1'b1) begin
        got = k + 1;
        break;
      end
    end
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL raw_latency lat=%0d edges=%0d want %0d", lat, got, want);
    end
  endtask

  task automatic test_intra_dep();
    send(mk(1, 0, 11'h0C5, 1, 0, 0, 3'b001, 12, 1, 1, 18'h5),
         mk(1, 1, 11'h1C6, 0, 12, 0, 3'b010, 13, 1, 1, 18'h6));
    tick();
    checks++;
    if (issue_ep !== 1'b1 || issue_op !== 1'b0 || pair_ready !== 1'b0) begin
      failures++;
      $display("FAIL intra_c1 issue=%b%b rdy=%b want 10 0",
               issue_ep, issue_op, pair_ready);
    end
    tick();
    checks++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b1 || opcode_op !== 11'h1C6 ||
        pair_ready !== 1'b1) begin
      failures++;
      $display("FAIL intra_c2 issue=%b%b op=%h rdy=%b want 01 1c6 1",
               issue_ep, issue_op, opcode_op, pair_ready);
    end
  endtask

  task automatic test_rst_stall();
    ins_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send(mk(1, 0, 11'h0C7, 1, 0, 0, 3'b001, 20, 1, 7, 18'h7), z);
    tick();
    send(mk(1, 0, 11'h0C8, 1, 0, 0, 3'b001, 21, 1, 1, 18'h8),
         mk(1, 1, 11'h1C9, 20, 0, 0, 3'b001, 22, 1, 1, 18'h9));
    tick();
    tick();
    checks++;
    if (issue_op !== 1'b0 || pair_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_pre issue_op=%b rdy=%b want 0 0",
               issue_op, pair_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b0 || opcode_ep !== NOP_EVEN ||
        opcode_op !== NOP_ODD || pair_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_async issue=%b%b op=%h/%h rdy=%b",
               issue_ep, issue_op, opcode_ep, opcode_op, pair_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    exp_rdy = (q.size() == 0);
    checks++;
    if (pair_ready !== 1'b1 || exp_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_stall_ready rdy=%b want 1", pair_ready);
    end
    send(mk(1, 1, 11'h1CA, 20, 0, 0, 3'b001, 23, 0, 1, 18'hA), z);
    tick();
    checks++;
    if (issue_op !== 1'b1 || opcode_op !== 11'h1CA || issue_ep !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_cleared issue=%b%b op=%h want 01 1ca",
               issue_ep, issue_op, opcode_op);
    end
    repeat (8) begin
      tick();
      checks++;
      if (issue_ep !== 1'b0 || issue_op !== 1'b0 || act_op !== exp_op) begin
        failures++;
        $display("FAIL rst_stall_stale issue=%b%b op=%h want 00",
                 issue_ep, issue_op, opcode_op);
      end
    end
  endtask

  task automatic test_empty_pair();
    ins_t z;
    z = mk(0, 0, 11'h0FF, 1, 2, 3, 3'b111, 4, 1, 3, 18'h1);
    send(z, z);
    checks++;
    if (pair_ready !== 1'b1 || issue_ep !== 1'b0 || issue_op !== 1'b0) begin
      failures++;
      $display("FAIL empty_pair rdy=%b issue=%b%b want 1 00",
               pair_ready, issue_ep, issue_op);
    end
    tick();
    checks++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b0 || pair_ready !== 1'b1) begin
      failures++;
      $display("FAIL empty_pair_next rdy=%b issue=%b%b want 1 00",
               pair_ready, issue_ep, issue_op);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      sl[0] = rnd();
      sl[1] = rnd();
      pair_valid = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (act_ep !== exp_ep || act_op !== exp_op || pair_ready !== exp_rdy) begin
        failures++;
        $display("FAIL random n=%0d ep=%h/%h op=%h/%h rdy=%b/%b", n,
                 act_ep, exp_ep, act_op, exp_op, pair_ready, exp_rdy);
      end
    end
    pair_valid = 1'b0;
  endtask

`ifdef SPU_ISSUE_PERF_EN
  task automatic test_perf();
    checks++;
    if (perf_dual !== 32'(m_dual) || perf_single !== 32'(m_single) ||
        perf_stall !== 32'(m_stall)) begin
      failures++;
      $display("FAIL perf d/s/st=%0d/%0d/%0d want %0d/%0d/%0d",
               perf_dual, perf_single, perf_stall, m_dual, m_single, m_stall);
    end
  endtask
`endif

  initial begin
    sl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sl[1] = sl[0];
    test_reset();
    test_indep_pair();
    test_same_pipe();
    test_raw(3'd6, 7'd10, 6);
    test_raw(3'd1, 7'd14, 2);
    test_intra_dep();
    test_rst_stall();
    test_empty_pair();
    test_random();
`ifdef SPU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
